vpifo_req_arbiter: RTL
======================

VPIFO_REQ_ARBITER -- requirements
Module: vpifo_req_arbiter

Interface
REQ-001 SHALL have parameter PTW, default 16, push/pop data width.
REQ-002 SHALL have parameter TREE_NUM, default 2, number of requesters (one per logical tree).
REQ-003 SHALL have parameter CAP, default 6, maximum elements per tree; CW = $clog2(CAP+1).
REQ-004 SHALL have parameter POP_LAT, default 2, PIFO pop-to-data latency in cycles (>=1).
REQ-005 SHALL have parameter INIT_CYC, default 4, post-reset cycles before the first issue; TB = $clog2(TREE_NUM), minimum 1.
REQ-006 SHALL have these ports:
- i_clk  in  1  single clock, rising edge.
- i_arst_n  in  1  asynchronous, active-low reset.
- i_req_push  in  TREE_NUM  per-tree push request.
- i_req_pop  in  TREE_NUM  per-tree pop request.
- i_req_data  in  TREE_NUM*PTW  per-tree push data; tree k uses bits [k*PTW +: PTW].
- o_req_ready  out  TREE_NUM  one-hot, combinational grant; request consumed when req & ready.
- o_push  out  1  registered push strobe to the PIFO level port.
- o_pop  out  1  registered pop strobe to the PIFO level port.
- o_tree_id  out  TB  registered tree id of the issued op.
- o_push_data  out  PTW  registered push data.
- i_task_fifo_full  in  1  PIFO backpressure.
- i_pop_data  in  PTW  PIFO pop data.
- o_rsp_valid  out  1  pop response valid.
- o_rsp_tree_id  out  TB  tree id of the response.
- o_rsp_data  out  PTW  response data; combinational copy of i_pop_data.
- o_count  out  TREE_NUM*CW  per-tree occupancy.
- o_init_done  out  1  high in RUN.

Function
REQ-007 SHALL implement FSM INIT->RUN: INIT counts INIT_CYC cycles after reset release, then moves to RUN permanently; grants are possible only in RUN.
REQ-008 SHALL treat tree k as push-eligible when i_req_push[k] & count[k]<CAP & !i_task_fifo_full.
REQ-009 SHALL treat tree k as pop-eligible when i_req_pop[k] & count[k]>0.
REQ-010 SHALL give a tree asserting both requests pop priority: the pop is granted only if pop-eligible; otherwise the push is evaluated.
REQ-011 SHALL grant at most one tree per cycle, round-robin: search starts at rr_ptr, and rr_ptr <= winner+1 (mod TREE_NUM) on grant; rr_ptr is unchanged when no tree is granted.
REQ-012 SHALL register the granted op: o_push or o_pop, o_tree_id, o_push_data valid exactly one cycle after grant; o_push and o_pop SHALL never be high together.
REQ-013 SHALL update count[k] at the grant edge: +1 on push grant, -1 on pop grant; it SHALL never exceed CAP or go below 0.
REQ-014 SHALL hold o_push_data at 0 when o_push is low.
REQ-015 SHALL track each issued pop in a POP_LAT-deep valid/tree-id delay line: o_rsp_valid rises exactly POP_LAT cycles after o_pop, with the matching o_rsp_tree_id; back-to-back pops SHALL produce back-to-back responses.
REQ-016 SHALL leave ineligible requests pending (ready low) without loss; requesters hold request and data until ready.
REQ-017 SHALL sample i_task_fifo_full in the grant cycle only; pops are unaffected by it.

Reset
REQ-018 SHALL, on i_arst_n low at any time including mid-operation, immediately clear all counts, rr_ptr, delay line, o_push, o_pop, o_tree_id, o_push_data, o_rsp_valid, and o_rsp_tree_id, and force INIT with o_init_done=0.
REQ-019 SHALL discard in-flight pop responses on reset; o_req_ready SHALL be 0 during reset and INIT.

Verification
REQ-020 Init: release reset, hold i_req_push=2'b11 -> o_req_ready=0 for 4 cycles; first grant to tree 0 in cycle 5; o_push=1 with o_tree_id=0 one cycle later.
REQ-021 Fill: both trees push continuously, 12 pushes (data 0..5 and 4096..4101) -> grants alternate 0,1,0,1; counts reach 6/6; further pushes get ready=0.
REQ-022 Drain: from full, both trees pop continuously -> 12 pops alternating; o_rsp_valid 2 cycles after each o_pop with the matching tree id; counts reach 0; further pops are blocked.
REQ-023 Backpressure: i_task_fifo_full=1 while tree 0 pushes and tree 1 pops (count 3) -> only tree 1 is granted; the push is granted in the first cycle after full drops.
REQ-024 Simultaneous: tree 0 asserts push+pop with count 0 -> push granted; with count 2 -> pop granted, push stays pending.
REQ-025 Mid-reset: assert reset one cycle after a pop issue -> no o_rsp_valid appears; counts read 0; INIT repeats.

Source files
------------

// File: rtl/vpifo_req_arbiter.sv
// Round-robin arbiter that merges per-tree push/pop requests onto one shared PIFO level port.
// Tracks per-tree occupancy and delays pop tags so they line up with the PIFO pop data.
module vpifo_req_arbiter #(
   parameter int PTW      = 16,
   parameter int TREE_NUM = 2,
   parameter int CAP      = 6,
   parameter int POP_LAT  = 2,
   parameter int INIT_CYC = 4,
   localparam int CW      = $clog2(CAP + 1),
   localparam int TB      = (TREE_NUM > 1) ? $clog2(TREE_NUM) : 1
) (
   input  logic                     i_clk,
   input  logic                     i_arst_n,
   input  logic [TREE_NUM-1:0]      i_req_push,
   input  logic [TREE_NUM-1:0]      i_req_pop,
   input  logic [TREE_NUM*PTW-1:0]  i_req_data,
   output logic [TREE_NUM-1:0]      o_req_ready,
   output logic                     o_push,
   output logic                     o_pop,
   output logic [TB-1:0]            o_tree_id,
   output logic [PTW-1:0]           o_push_data,
   input  logic                     i_task_fifo_full,
   input  logic [PTW-1:0]           i_pop_data,
   output logic                     o_rsp_valid,
   output logic [TB-1:0]            o_rsp_tree_id,
   output logic [PTW-1:0]           o_rsp_data,
   output logic [TREE_NUM*CW-1:0]   o_count,
   output logic                     o_init_done
);

   localparam int IW = (INIT_CYC > 1) ? $clog2(INIT_CYC) : 1;

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   state_t               state, state_next;
   logic [IW-1:0]        init_cnt;
   logic [TB-1:0]        rr_ptr;
   logic [CW-1:0]        count [TREE_NUM];
   logic [TREE_NUM-1:0]  push_ok, pop_ok;
   logic                 gnt, gnt_pop;
   logic [TB-1:0]        gnt_id, scan_id;
   logic [PTW-1:0]       gnt_data;
   int                   scan_idx;
   logic [POP_LAT-1:0]   dl_valid;
   logic [TB-1:0]        dl_id [POP_LAT];

   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         state    <= ST_INIT;
         init_cnt <= '0;
      end else begin
         state <= state_next;
         if (state == ST_INIT)
            init_cnt <= init_cnt + 1'b1;
      end
   end

   always_comb begin
      state_next = state;
      if (state == ST_INIT && init_cnt == IW'(INIT_CYC - 1))
         state_next = ST_RUN;
   end

   // Pop wins over push for a tree asserting both, but only when there is something to pop.
   always_comb begin
      for (int k = 0; k < TREE_NUM; k++) begin
         pop_ok[k]  = i_req_pop[k] && (count[k] != '0);
         push_ok[k] = i_req_push[k] && (count[k] < CW'(CAP)) && !i_task_fifo_full;
      end
   end

   always_comb begin
      gnt      = 1'b0;
      gnt_pop  = 1'b0;
      gnt_id   = '0;
      scan_idx = 0;
      scan_id  = '0;
      if (state == ST_RUN) begin
         for (int i = 0; i < TREE_NUM; i++) begin
            scan_idx = int'(rr_ptr) + i;
            if (scan_idx >= TREE_NUM)
               scan_idx = scan_idx - TREE_NUM;
            scan_id = TB'(scan_idx);
            if (!gnt && (pop_ok[scan_id] || push_ok[scan_id])) begin
               gnt     = 1'b1;
               gnt_id  = scan_id;
               gnt_pop = pop_ok[scan_id];
            end
         end
      end
   end

   always_comb begin
      o_req_ready = '0;
      if (gnt)
         o_req_ready[gnt_id] = 1'b1;
   end

   assign gnt_data = i_req_data[gnt_id*PTW +: PTW];

   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         o_push      <= 1'b0;
         o_pop       <= 1'b0;
         o_tree_id   <= '0;
         o_push_data <= '0;
         rr_ptr      <= '0;
         for (int k = 0; k < TREE_NUM; k++)
            count[k] <= '0;
      end else begin
         o_push      <= gnt && !gnt_pop;
         o_pop       <= gnt && gnt_pop;
         o_tree_id   <= gnt_id;
         o_push_data <= (gnt && !gnt_pop) ? gnt_data : '0;
         if (gnt) begin
            rr_ptr <= (gnt_id == TB'(TREE_NUM - 1)) ? '0 : gnt_id + 1'b1;
            if (gnt_pop)
               count[gnt_id] <= count[gnt_id] - 1'b1;
            else
               count[gnt_id] <= count[gnt_id] + 1'b1;
         end
      end
   end

   // Pop tags ride this shift line so each response carries the tree it was issued for.
   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         dl_valid <= '0;
         for (int i = 0; i < POP_LAT; i++)
            dl_id[i] <= '0;
      end else begin
         dl_valid[0] <= o_pop;
         dl_id[0]    <= o_tree_id;
         for (int i = 1; i < POP_LAT; i++) begin
            dl_valid[i] <= dl_valid[i-1];
            dl_id[i]    <= dl_id[i-1];
         end
      end
   end

   assign o_rsp_valid   = dl_valid[POP_LAT-1];
   assign o_rsp_tree_id = dl_id[POP_LAT-1];
   assign o_rsp_data    = i_pop_data;
   assign o_init_done   = (state == ST_RUN);

   always_comb begin
      o_count = '0;
      for (int k = 0; k < TREE_NUM; k++)
         o_count[k*CW +: CW] = count[k];
   end

endmodule
